os_result_drain: RTL and testbench

OS_RESULT_DRAIN -- requirements
Module: os_result_drain

---
 rtl/os_result_drain_pkg.sv | 21 ++
 rtl/os_result_drain_if.sv | 34 +++
 rtl/os_result_drain_csa_resolve.sv | 14 +
 rtl/os_result_drain.sv | 145 ++++++++++++++
 tb/tb_os_result_drain.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/os_result_drain_pkg.sv
// Shared types for the output-stationary result drain.
// FSM encoding and index-width helper.
package os_result_drain_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Bits needed to index n entries (n >= 2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/os_result_drain_if.sv
// Valid/ready result stream from the drain.
// Master drives words, slave drives ready.
interface os_result_drain_if
  import os_result_drain_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int N         = 4
) ();

  localparam int IW = clog2(N);

  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic [IW-1:0]        out_idx;
  logic                 out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/os_result_drain_csa_resolve.sv
// Carry-save resolve: sum + carry, wrapping.
// Carry-out is dropped on purpose.
module csa_resolve #(
  parameter int ACC_WIDTH = 32
) (
  input  logic [ACC_WIDTH-1:0] sum,
  input  logic [ACC_WIDTH-1:0] carry,
  output logic [ACC_WIDTH-1:0] res
);

  // Modular add of the two accumulator halves.
  assign res = sum + carry;

endmodule

// File: rtl/os_result_drain.sv
// Drains one PE column: capture, clear, stream.
// One word per cycle through a single adder.
module os_result_drain
  import os_result_drain_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int N         = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [N*2*ACC_WIDTH-1:0]   pe_result,
  output logic                       clc,
  output logic                       busy,
  output logic                       overrun,
  os_result_drain_if.master          out
);

  localparam int W  = ACC_WIDTH;
  localparam int IW = clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t state_q;
  state_t state_d;

  logic [2*W-1:0] hold_q [N];

  logic          capture;
  logic          load_first;
  logic          advance;
  logic          finish;
  logic          xfer;

  logic          valid_q;
  logic [W-1:0]  data_q;
  logic [IW-1:0] idx_q;
  logic          clc_q;
  logic          overrun_q;

  logic [IW-1:0] nxt;
  logic [IW-1:0] sel;
  logic [W-1:0]  op_sum;
  logic [W-1:0]  op_carry;
  logic [W-1:0]  res;

  assign xfer = valid_q && out.out_ready;

  // Next-state and datapath strobes.
  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    load_first = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          capture = 1'b1;
        end
      end
      CLEAR: begin
        state_d    = STREAM;
        load_first = 1'b1;
      end
      STREAM: begin
        if (xfer) begin
          if (idx_q == LAST) begin
            state_d = IDLE;
            finish  = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Holding registers, written only on capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) hold_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < N; i++) begin
        hold_q[i] <= pe_result[i*2*W +: 2*W];
      end
    end
  end

  // Operand select for the shared adder.
  assign nxt = idx_q + IW'(1);
  assign sel = (load_first || int'(nxt) >= N) ? '0 : nxt;

  assign op_sum   = hold_q[sel][2*W-1:W];
  assign op_carry = hold_q[sel][W-1:0];

  csa_resolve #(
    .ACC_WIDTH (W)
  ) u_resolve (
    .sum   (op_sum),
    .carry (op_carry),
    .res   (res)
  );

  // Output word, index and strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      idx_q     <= '0;
      clc_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      clc_q     <= (state_d == CLEAR);
      overrun_q <= start && (state_q != IDLE);
      if (load_first) begin
        valid_q <= 1'b1;
        data_q  <= res;
        idx_q   <= '0;
      end else if (advance) begin
        data_q <= res;
        idx_q  <= sel;
      end else if (finish) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out.out_valid = valid_q;
  assign out.out_data  = data_q;
  assign out.out_idx   = idx_q;
  assign out.out_last  = valid_q && (idx_q == LAST);

  assign clc     = clc_q;
  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_os_result_drain.sv
// Bench for os_result_drain: vector table,
// scoreboard and multi-cycle corner cases.
module tb_os_result_drain;
  import os_result_drain_pkg::*;

  localparam int W = 32;
  localparam int N = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [N*2*W-1:0] pe_result;
  logic             clc;
  logic             busy;
  logic             overrun;

  os_result_drain_if #(.ACC_WIDTH(W), .N(N)) dif ();

  os_result_drain #(
    .ACC_WIDTH (W),
    .N         (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pe_result (pe_result),
    .clc       (clc),
    .busy      (busy),
    .overrun   (overrun),
    .out       (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   idx;
  } exp_t;

  typedef struct {
    logic [N-1:0][W-1:0] sum;
    logic [N-1:0][W-1:0] carry;
    logic [N-1:0][W-1:0] exp;
    logic [7:0]          rdy;
  } vec_t;

  exp_t sbq[$];
  exp_t e;
  vec_t vecs[4];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: scoreboard pops and stall stability.
  logic         stall_p = 1'b0;
  logic [W-1:0] data_p;
  logic [1:0]   idx_p;

  always @(negedge clk) begin
    if (rst) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        chk("hold_valid", dif.out_valid, 1);
        chk("hold_data", dif.out_data, data_p);
        chk("hold_idx", dif.out_idx, idx_p);
      end
      if (dif.out_valid && dif.out_ready) begin
        if (sbq.size() == 0) begin
          chk("extra_word", sbq.size(), 1);
        end else begin
          e = sbq.pop_front();
          chk("word_data", dif.out_data, e.data);
          chk("word_idx", dif.out_idx, e.idx);
          chk("word_last", dif.out_last, e.idx == 2'd3);
        end
      end
      stall_p = dif.out_valid && !dif.out_ready;
      data_p  = dif.out_data;
      idx_p   = dif.out_idx;
    end
  end

  task automatic scramble();
    for (int i = 0; i < 2*N; i++) pe_result[i*W +: W] = $urandom;
  endtask

  // Drive start for one edge and push expected words.
  task automatic launch(input vec_t v);
    for (int i = 0; i < N; i++) begin
      pe_result[i*2*W +: 2*W] = {v.sum[i], v.carry[i]};
      sbq.push_back('{data: v.exp[i], idx: 2'(i)});
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int clc_cnt;
    bit done;
    clc_cnt = 0;
    done = 0;
    launch(v);
    for (int k = 1; k < 40 && !done; k++) begin
      dif.out_ready = (k >= 2 && k < 10) ? v.rdy[k-2] : 1'b1;
      scramble();
      @(negedge clk);
      if (k == 1) begin
        chk({tag, "_clc_t1"}, clc, 1);
        chk({tag, "_valid_t1"}, dif.out_valid, 0);
        chk({tag, "_busy_t1"}, busy, 1);
      end
      if (k == 2) begin
        chk({tag, "_valid_t2"}, dif.out_valid, 1);
        chk({tag, "_idx_t2"}, dif.out_idx, 0);
      end
      clc_cnt += int'(clc);
      @(posedge clk);
      #1;
      if (k >= 2 && !busy) done = 1;
    end
    chk({tag, "_clc_pulses"}, clc_cnt, 1);
    chk({tag, "_drained"}, sbq.size(), 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int ovr_cnt;

    for (int i = 0; i < N; i++) begin
      vecs[0].sum[i]   = 32'h10 * i + 1;
      vecs[0].carry[i] = 32'h100;
      vecs[0].exp[i]   = 32'h101 + 32'h10 * i;
    end
    vecs[0].rdy = 8'hFF;

    vecs[1].sum   = {32'h12345678, 32'h00000000, 32'h80000000, 32'hFFFFFFFF};
    vecs[1].carry = {32'h11111111, 32'h00000000, 32'h80000000, 32'h00000002};
    vecs[1].exp   = {32'h23456789, 32'h00000000, 32'h00000000, 32'h00000001};
    vecs[1].rdy   = 8'hFF;

    vecs[2].sum   = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
    vecs[2].carry = {32'h00003C00, 32'h00002D00, 32'h00001E00, 32'h00000F00};
    vecs[2].exp   = {32'hA0003C03, 32'hA0002D02, 32'hA0001E01, 32'hA0000F00};
    vecs[2].rdy   = 8'b1111_0001;

    vecs[3].sum   = {32'h00000000, 32'hDEADBEEF, 32'h00000001, 32'h7FFFFFFF};
    vecs[3].carry = {32'hFFFFFFFF, 32'h01010101, 32'hFFFFFFFF, 32'h00000001};
    vecs[3].exp   = {32'hFFFFFFFF, 32'hDFAEBFF0, 32'h00000000, 32'h80000000};
    vecs[3].rdy   = 8'b0101_0101;

    rst = 1'b1;
    start = 1'b0;
    pe_result = '0;
    dif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", dif.out_valid, 0);
    chk("rst_data", dif.out_data, 0);
    chk("rst_idx", dif.out_idx, 0);
    chk("rst_last", dif.out_last, 0);
    chk("rst_clc", clc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    @(posedge clk);
    #1;

    for (int v = 0; v < 4; v++) begin
      run_vec(vecs[v], $sformatf("vec%0d", v));
    end

    // Start while busy and on the final transfer.
    ovr_cnt = 0;
    dif.out_ready = 1'b1;
    launch(vecs[0]);
    for (int k = 1; k <= 8; k++) begin
      start = (k == 3 || k == 5);
      scramble();
      @(negedge clk);
      ovr_cnt += int'(overrun);
      if (k == 4) chk("ovr_c4", overrun, 1);
      if (k == 6) begin
        chk("ovr_c6", overrun, 1);
        chk("ovr_busy_c6", busy, 0);
      end
      if (k == 7) begin
        chk("ovr_no_restart_clc", clc, 0);
        chk("ovr_no_restart_busy", busy, 0);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("ovr_count", ovr_cnt, 2);
    chk("ovr_drained", sbq.size(), 0);

    // Reset after idx 1 has been accepted.
    dif.out_ready = 1'b1;
    launch(vecs[2]);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("mid_before_rst_idx", dif.out_idx, 2);
    rst = 1'b1;
    dif.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    dif.out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", dif.out_valid, 0);
    chk("mid_rst_data", dif.out_data, 0);
    chk("mid_rst_idx", dif.out_idx, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_clc", clc, 0);
    chk("mid_rst_overrun", overrun, 0);
    @(posedge clk);
    #1;
    run_vec(vecs[1], "fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
